vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
// - Upstream stage of the game engine. Generates the raster scan position (pix_x, pix_y),
//   the active-video flag (pix_v), the frame counter (frame_id), and the VGA hsync/vsync pins.
// - Divides the system clock down to the pixel rate.
// - Default timing: 640x480@60, 50 MHz clk, 25 MHz pixel tick.
// PARAMETERS
// pA        10   width of pix_x / pix_y
// fA        32   width of frame_id
// CLK_DIV   2    clk cycles per pixel (>=1)
// H_ACTIVE  640  visible pixels per line
// H_FP      16   horizontal front porch (pixels)
// H_SYNC    96   hsync width (pixels)
// H_BP      48   horizontal back porch (pixels)
// V_ACTIVE  480  visible lines
// V_FP      10   vertical front porch (lines)
// V_SYNC    2    vsync width (lines)
// V_BP      33   vertical back porch (lines)
// SYNC_POL  0    0 = sync pulses active-low, 1 = active-high
// PORTS
// clk         in   1   system clock
// rst         in   1   asynchronous, active-high reset
// pix_tick    out  1   high in the clk cycle at whose end the counters advance
// pix_x       out  pA  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = 800)
// pix_y       out  pA  vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525)
// pix_v       out  1   1 when pix_x < H_ACTIVE and pix_y < V_ACTIVE
// frame_id    out  fA  completed-frame count, wraps modulo 2**fA
// frame_start out  1   1-clk pulse on the first clk at (0,0) after a frame wrap
// hsync       out  1   horizontal sync, polarity set by SYNC_POL
// vsync       out  1   vertical sync, polarity set by SYNC_POL
// BEHAVIOUR
// - Reset (async, immediate, also when asserted mid-frame):
//   div=0, pix_x=0, pix_y=0, pix_v=1, frame_id=0, frame_start=0, hsync=vsync=inactive.
// - Divider:
//   - div counts 0..CLK_DIV-1 and wraps.
//   - pix_tick = (div==CLK_DIV-1), decoded from the div register.
//   - With CLK_DIV=1, pix_tick is constant 1.
// - Horizontal counter: on a clk edge with pix_tick=1, pix_x increments. At H_TOTAL-1 it wraps to 0.
// - Vertical counter: increments only on a pix_x wrap. At V_TOTAL-1 (same edge as the pix_x wrap) it wraps to 0.
// - Frame counter: frame_id increments on the edge where both counters wrap. At 2**fA-1 it wraps to 0.
// - frame_start:
//   - Registered. High for exactly one clk, the cycle immediately after the double wrap.
//   - Never asserted out of reset.
// - Sync:
//   - hsync is active for H_ACTIVE+H_FP <= pix_x < H_ACTIVE+H_FP+H_SYNC (656..751).
//   - vsync is active for V_ACTIVE+V_FP <= pix_y < V_ACTIVE+V_FP+V_SYNC (490..491).
// - Alignment:
//   - pix_v, hsync, vsync, frame_id and frame_start are flops loaded from next-state counter values.
//   - Every output therefore describes the same (pix_x, pix_y) in the same cycle: zero skew, glitch-free pins.
// - Between ticks all outputs hold. Outputs change only on clk edges with pix_tick=1 (frame_start clears the next clk).
// - Widths: H_TOTAL-1 and V_TOTAL-1 must fit in pA bits. This is checked with an elaboration-time $error.
// STRUCTURE
// - Package vga_pkg holds:
//   - typedef vga_timing_t (active, fp, sync, bp);
//   - constants VGA_640x480_H / VGA_640x480_V;
//   - function total(vga_timing_t).
// - Sub-module vga_axis_timer: wrap counter plus active/sync decode. Inputs are step and timing; outputs are cnt, wrap, active, sync.
//   Instantiated twice: H stepped by pix_tick, V stepped by the H wrap.
// - The top level holds the divider, frame_id, frame_start, and the polarity/output registers.
// TESTING
// 1. Release reset, CLK_DIV=2 -> pix_x steps every 2 clks; line period 1600 clks; frame period 840000 clks.
// 2. Scan line 0 -> pix_v=1 for pix_x 0..639 and 0 from 640; hsync=0 for pix_x 656..751 (192 clks); 1 otherwise.
// 3. Full frame -> vsync=0 exactly on lines 490..491; pix_v=0 on all lines >=480.
// 4. Wrap (799,524)->(0,0) -> frame_id 0->1 and frame_start one clk high in the same cycle as (0,0); no pulse at reset release.
// 5. Assert rst at (300,200), frame_id=3 -> next sample: (0,0), frame_id=0, syncs inactive, div=0 without waiting for clk.
// 6. CLK_DIV=1, fA=4, SYNC_POL=1 -> pix_tick constant 1; 800-clk lines; syncs active-high; frame_id 15->0 after the 16th frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing types, standard mode constants and helpers for the VGA raster generator.
package vga_pkg;

    localparam int TW = 16;
    typedef logic [TW-1:0] tval_t;

    // One axis of raster timing, all counts in pixels (H) or lines (V).
    typedef struct packed {
        tval_t active;
        tval_t fp;
        tval_t sync;
        tval_t bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
    localparam vga_timing_t VGA_640x480_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33};

    // Full period of one axis.
    function automatic tval_t total(input vga_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: wrapping position counter plus active/sync decode of the
// value the counter will hold after this clock, so the parent can register
// the decodes and have them line up with the counter.
module vga_axis_timer
    import vga_pkg::*;
#(
    parameter int W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  vga_timing_t timing,
    output logic [W-1:0] cnt,
    output logic        wrap,
    output logic        active,
    output logic        sync
);

    tval_t        last;
    tval_t        sync_lo;
    tval_t        sync_hi;
    tval_t        nxt_w;
    logic [W-1:0] cnt_nxt;

    // Next count, wrap strobe and decodes of the next count.
    always_comb begin
        last    = total(timing) - tval_t'(1);
        sync_lo = timing.active + timing.fp;
        sync_hi = sync_lo + timing.sync;
        wrap    = step && (tval_t'(cnt) == last);
        cnt_nxt = cnt;
        if (wrap) begin
            cnt_nxt = '0;
        end else if (step) begin
            cnt_nxt = cnt + W'(1);
        end
        nxt_w  = tval_t'(cnt_nxt);
        active = (nxt_w < timing.active);
        sync   = (nxt_w >= sync_lo) && (nxt_w < sync_hi);
    end

    // Position register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate divider, H/V position counters,
// frame counter and registered, zero-skew video/sync outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int pA       = 10,
    parameter int fA       = 32,
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          pix_tick,
    output logic [pA-1:0] pix_x,
    output logic [pA-1:0] pix_y,
    output logic          pix_v,
    output logic [fA-1:0] frame_id,
    output logic          frame_start,
    output logic          hsync,
    output logic          vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam vga_timing_t H_T = '{active: tval_t'(H_ACTIVE), fp: tval_t'(H_FP),
                                    sync: tval_t'(H_SYNC), bp: tval_t'(H_BP)};
    localparam vga_timing_t V_T = '{active: tval_t'(V_ACTIVE), fp: tval_t'(V_FP),
                                    sync: tval_t'(V_SYNC), bp: tval_t'(V_BP)};

    generate
        if (H_TOTAL - 1 >= (1 << pA)) begin : g_h_width_chk
            $error("vga_timing_gen: H_TOTAL-1 does not fit in pA bits");
        end
        if (V_TOTAL - 1 >= (1 << pA)) begin : g_v_width_chk
            $error("vga_timing_gen: V_TOTAL-1 does not fit in pA bits");
        end
        if (CLK_DIV < 1) begin : g_div_chk
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [DIV_W-1:0] div;
    logic             h_wrap, h_act, h_sync;
    logic             v_wrap, v_act, v_sync;

    // With CLK_DIV=1 div never leaves 0, so the tick decodes as constant 1.
    assign pix_tick = (div == DIV_W'(CLK_DIV - 1));

    vga_axis_timer #(.W(pA)) u_h (
        .clk    (clk),
        .rst    (rst),
        .step   (pix_tick),
        .timing (H_T),
        .cnt    (pix_x),
        .wrap   (h_wrap),
        .active (h_act),
        .sync   (h_sync)
    );

    vga_axis_timer #(.W(pA)) u_v (
        .clk    (clk),
        .rst    (rst),
        .step   (h_wrap),
        .timing (V_T),
        .cnt    (pix_y),
        .wrap   (v_wrap),
        .active (v_act),
        .sync   (v_sync)
    );

    // Divider, frame counter and output flops; v_wrap already implies h_wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= '0;
            pix_v       <= 1'b1;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_id    <= '0;
            frame_start <= 1'b0;
        end else begin
            div         <= pix_tick ? '0 : div + DIV_W'(1);
            pix_v       <= h_act && v_act;
            hsync       <= h_sync ? SYNC_POL : ~SYNC_POL;
            vsync       <= v_sync ? SYNC_POL : ~SYNC_POL;
            frame_start <= v_wrap;
            if (v_wrap) begin
                frame_id <= frame_id + fA'(1);
            end
        end
    end

endmodule
